// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: one requester owns the shared resource
// from grant until last beat, abandon, or stall timeout.
module rr_burst_arbiter #(
   parameter  int N_REQ       = 4,
   parameter  int TIMEOUT_CYC = 64,
   localparam int IW          = $clog2(N_REQ),
   localparam int SW          = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] valid,
   input  logic [N_REQ-1:0] last,
   input  logic             res_ready,
   output logic [N_REQ-1:0] ack,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    gnt_id,
   output logic             busy,
   output logic             res_valid,
   output logic             res_last,
   output logic             timeout_err
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t           r_state, w_nxt_state;
   logic [N_REQ-1:0] r_gnt, w_nxt_gnt;
   logic [IW-1:0]    r_gnt_id, w_nxt_gnt_id;
   logic [IW-1:0]    r_ptr, w_nxt_ptr;
   logic [SW-1:0]    r_stall, w_nxt_stall;
   logic             r_busy, w_nxt_busy;
   logic             r_tout, w_nxt_tout;
   logic [IW-1:0]    w_win;
   logic             w_fire;
   logic             w_rel_last;
   logic             w_aband;
   logic             w_tout_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_ptr    <= '0;
         r_stall  <= '0;
         r_busy   <= 1'b0;
         r_tout   <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_gnt    <= w_nxt_gnt;
         r_gnt_id <= w_nxt_gnt_id;
         r_ptr    <= w_nxt_ptr;
         r_stall  <= w_nxt_stall;
         r_busy   <= w_nxt_busy;
         r_tout   <= w_nxt_tout;
      end
   end

   // scan downward so the lowest offset from r_ptr wins
   always_comb begin
      int j;
      w_win = '0;
      j = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = int'(r_ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (req[j]) w_win = IW'(j);
      end
   end

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_gnt    = r_gnt;
      w_nxt_gnt_id = r_gnt_id;
      w_nxt_ptr    = r_ptr;
      w_nxt_stall  = r_stall;
      w_nxt_busy   = r_busy;
      w_nxt_tout   = 1'b0;
      w_rel_last   = w_fire & last[r_gnt_id];
      w_aband      = ~req[r_gnt_id] & ~w_fire;
      w_tout_hit   = ~valid[r_gnt_id] &
                     (r_stall == SW'(TIMEOUT_CYC - 1));
      unique case (r_state)
         S_IDLE: begin
            if (|req) begin
               w_nxt_state         = S_GRANT;
               w_nxt_gnt           = '0;
               w_nxt_gnt[w_win]    = 1'b1;
               w_nxt_gnt_id        = w_win;
               w_nxt_busy          = 1'b1;
               w_nxt_stall         = '0;
            end
         end
         S_GRANT: begin
            if (w_rel_last | w_aband | w_tout_hit) begin
               w_nxt_state = S_IDLE;
               w_nxt_gnt   = '0;
               w_nxt_busy  = 1'b0;
               w_nxt_tout  = ~w_rel_last & ~w_aband;
               w_nxt_ptr   = (r_gnt_id == IW'(N_REQ - 1)) ?
                             '0 : r_gnt_id + IW'(1);
            end else if (valid[r_gnt_id]) begin
               w_nxt_stall = '0;
            end else if (r_stall < SW'(TIMEOUT_CYC)) begin
               w_nxt_stall = r_stall + SW'(1);
            end
         end
      endcase
   end

   always_comb begin
      w_fire    = r_busy & valid[r_gnt_id] & res_ready;
      ack       = r_gnt & {N_REQ{w_fire}};
      res_valid = r_busy & valid[r_gnt_id];
      res_last  = res_valid & last[r_gnt_id];
   end

   assign gnt         = r_gnt;
   assign gnt_id      = r_gnt_id;
   assign busy        = r_busy;
   assign timeout_err = r_tout;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter (N_REQ=4 and an N_REQ=3 instance).
module tb_rr_burst_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0, valid = '0, last = '0;
   logic       res_ready = 1'b0;
   logic [3:0] ack, gnt;
   logic [1:0] gnt_id;
   logic       busy, res_valid, res_last, timeout_err;

   logic [2:0] req3 = '0, valid3 = '0, last3 = '0;
   logic [2:0] ack3, gnt3;
   logic [1:0] gnt_id3;
   logic       busy3, res_valid3, res_last3, tout3;

   int n_tests = 0;
   int n_fail  = 0;

   rr_burst_arbiter #(.N_REQ(4), .TIMEOUT_CYC(64)) u_dut (
      .clk(clk), .rst(rst), .req(req), .valid(valid), .last(last),
      .res_ready(res_ready), .ack(ack), .gnt(gnt), .gnt_id(gnt_id),
      .busy(busy), .res_valid(res_valid), .res_last(res_last),
      .timeout_err(timeout_err)
   );

   rr_burst_arbiter #(.N_REQ(3), .TIMEOUT_CYC(64)) u_dut3 (
      .clk(clk), .rst(rst), .req(req3), .valid(valid3), .last(last3),
      .res_ready(res_ready), .ack(ack3), .gnt(gnt3), .gnt_id(gnt_id3),
      .busy(busy3), .res_valid(res_valid3), .res_last(res_last3),
      .timeout_err(tout3)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int bad;
      int ord4[5];
      int ord3[5];
      ord4 = '{0, 1, 2, 3, 0};
      ord3 = '{0, 1, 2, 0, 1};

      // 1: reset with random inputs
      repeat (3) begin
         tick();
         req = 4'($urandom); valid = 4'($urandom);
         last = 4'($urandom); res_ready = 1'($urandom);
         #1;
         chk("rst_gnt", 32'(gnt), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_ack", 32'(ack), 0);
         chk("rst_tout", 32'(timeout_err), 0);
      end
      req = 4'b1111; valid = '0; last = '0; res_ready = 1'b0;
      rst = 1'b0;
      tick();
      chk("t1_first", 32'(gnt), 32'b0001);
      chk("t1_id", 32'(gnt_id), 0);
      req = '0;
      tick();
      chk("t1_aband_gnt", 32'(gnt), 0);
      chk("t1_aband_err", 32'(timeout_err), 0);

      // 2: three-beat burst from requester 0 (ptr now 1)
      req = 4'b0001; valid = 4'b0001; res_ready = 1'b1;
      tick();
      chk("t2_gnt", 32'(gnt), 32'b0001);
      chk("t2_ack1", 32'(ack), 32'b0001);
      chk("t2_rlast1", 32'(res_last), 0);
      tick();
      valid = 4'b1111; last = 4'b1110;
      #1;
      chk("t2_ack2", 32'(ack), 32'b0001);
      chk("t2_ign_last", 32'(res_last), 0);
      tick();
      valid = 4'b0001; last = 4'b0001;
      #1;
      chk("t2_ack3", 32'(ack), 32'b0001);
      chk("t2_rlast3", 32'(res_last), 1);
      tick();
      chk("t2_rel", 32'(gnt), 0);
      chk("t2_busy", 32'(busy), 0);
      req = 4'b1111; valid = '0; last = '0;
      tick();
      chk("t2_next", 32'(gnt), 32'b0010);
      req = '0;
      tick();

      // 3: round-robin order after a fresh reset
      rst = 1'b1;
      #1;
      rst = 1'b0;
      req = 4'b1111; valid = 4'b1111; last = 4'b1111; res_ready = 1'b1;
      req3 = 3'b111; valid3 = 3'b111; last3 = 3'b111;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_gnt", 32'(gnt), 32'(1 << ord4[i]));
         chk("t3_id", 32'(gnt_id), 32'(ord4[i]));
         chk("t3_ack", 32'(ack), 32'(1 << ord4[i]));
         chk("t3_gnt3", 32'(gnt3), 32'(1 << ord3[i]));
         tick();
         chk("t3_bubble", 32'(busy), 0);
         chk("t3_bubble3", 32'(busy3), 0);
      end
      req = '0; valid = '0; last = '0; res_ready = 1'b0;
      req3 = '0; valid3 = '0; last3 = '0;

      // 4: backpressure never times out (ptr now 1)
      req = 4'b0100; valid = 4'b0100;
      tick();
      chk("t4_gnt", 32'(gnt), 32'b0100);
      bad = 0;
      repeat (100) begin
         tick();
         if (ack !== 4'b0000 || gnt !== 4'b0100 || timeout_err !== 1'b0)
            bad++;
      end
      chk("t4_hold", 32'(bad), 0);
      res_ready = 1'b1; last = 4'b0100;
      #1;
      chk("t4_ack", 32'(ack), 32'b0100);
      chk("t4_rlast", 32'(res_last), 1);
      tick();
      chk("t4_rel", 32'(gnt), 0);
      chk("t4_err", 32'(timeout_err), 0);
      valid = '0; last = '0; res_ready = 1'b0;

      // 5: stall timeout on requester 1 (ptr now 3)
      req = 4'b0010;
      tick();
      chk("t5_gnt", 32'(gnt), 32'b0010);
      bad = 0;
      repeat (63) begin
         tick();
         if (gnt !== 4'b0010 || timeout_err !== 1'b0) bad++;
      end
      chk("t5_hold", 32'(bad), 0);
      tick();
      chk("t5_tout", 32'(timeout_err), 1);
      chk("t5_rel", 32'(gnt), 0);
      req = 4'b0110;
      tick();
      chk("t5_pulse", 32'(timeout_err), 0);
      chk("t5_next", 32'(gnt), 32'b0100);
      req = 4'b0100;
      repeat (63) tick();
      valid = 4'b0100; last = 4'b0100; res_ready = 1'b1;
      #1;
      chk("t5_ack64", 32'(ack), 32'b0100);
      tick();
      chk("t5_rel64", 32'(gnt), 0);
      chk("t5_noerr", 32'(timeout_err), 0);
      valid = '0; last = '0;

      // 6: async reset mid-burst (ptr now 3)
      req = 4'b1000;
      tick();
      chk("t6_gnt", 32'(gnt), 32'b1000);
      valid = 4'b1000;
      tick();
      rst = 1'b1;
      #1;
      chk("t6_rst_gnt", 32'(gnt), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_ack", 32'(ack), 0);
      rst = 1'b0;
      req = 4'b1111; valid = '0;
      tick();
      chk("t6_after", 32'(gnt), 32'b0001);
      chk("t6_rvalid", 32'(res_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
